// File: rtl/ps2_mouse_decoder_pkg.sv
// ps2_pkg: shared frame, packet and byte-0 field definitions for the PS/2 mouse decoder
package ps2_pkg;
   localparam int FRAME_BITS = 11;
   localparam int BIT_START = 0;
   localparam int BIT_PARITY = 9;
   localparam int BIT_STOP = 10;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_CHECK} frame_state_e;
   localparam logic [1:0] PKT_B0 = 2'd0;
   localparam logic [1:0] PKT_B1 = 2'd1;
   localparam logic [1:0] PKT_B2 = 2'd2;
   localparam int B0_L = 0;
   localparam int B0_R = 1;
   localparam int B0_M = 2;
   localparam int B0_SYNC = 3;
   localparam int B0_XS = 4;
   localparam int B0_YS = 5;
   localparam int B0_XO = 6;
   localparam int B0_YO = 7;
   localparam int DEFAULT_TIMEOUT = 50000;
   typedef struct packed {
      logic y_ovf;
      logic x_ovf;
      logic y_sign;
      logic x_sign;
      logic m;
      logic r;
      logic l;
   } pkt_hdr_t;
   // The sync bit only gates acceptance of byte 0, so it is not kept.
   function automatic pkt_hdr_t hdr_of(input logic [7:0] b);
      return '{y_ovf: b[B0_YO], x_ovf: b[B0_XO], y_sign: b[B0_YS], x_sign: b[B0_XS],
               m: b[B0_M], r: b[B0_R], l: b[B0_L]};
   endfunction
endpackage

// File: rtl/ps2_mouse_decoder_rx_frame.sv
// ps2_rx_frame: synchronises the PS/2 lines and deserialises 11-bit frames into bytes
module ps2_rx_frame
   import ps2_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   input  logic       abort,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       byte_error,
   output logic       start_error,
   output logic       fall,
   output logic       busy
);
   logic [2:0] clk_sync_q, clk_sync_d;
   logic [1:0] dat_sync_q, dat_sync_d;
   logic fall_q, fall_d;
   frame_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [FRAME_BITS-2:0] sr_q, sr_d;
   logic din, frame_ok, start_err;
   always_comb begin
      clk_sync_d = {clk_sync_q[1:0], ps2_clk};
      dat_sync_d = {dat_sync_q[0], ps2_data};
      fall_d = clk_sync_q[2] & ~clk_sync_q[1];
      din = dat_sync_q[1];
      frame_ok = (^sr_q[BIT_PARITY-1:0]) & sr_q[BIT_STOP-1];
      state_d = state_q;
      cnt_d = cnt_q;
      sr_d = sr_q;
      start_err = 1'b0;
      if (abort)
         state_d = ST_IDLE;
      else
         unique case (state_q)
            ST_IDLE:
               if (fall_q) begin
                  state_d = din ? ST_IDLE : ST_SHIFT;
                  cnt_d = 4'd1;
                  start_err = din;
               end
            ST_SHIFT:
               if (fall_q) begin
                  sr_d = {din, sr_q[FRAME_BITS-2:1]};
                  cnt_d = cnt_q + 4'd1;
                  state_d = (cnt_q == 4'(BIT_STOP)) ? ST_CHECK : ST_SHIFT;
               end
            default: state_d = ST_IDLE;
         endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         clk_sync_q <= '1;
         dat_sync_q <= '1;
         fall_q <= 1'b0;
         state_q <= ST_IDLE;
         cnt_q <= '0;
         sr_q <= '0;
      end else begin
         clk_sync_q <= clk_sync_d;
         dat_sync_q <= dat_sync_d;
         fall_q <= fall_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         sr_q <= sr_d;
      end
   assign byte_data = sr_q[7:0];
   assign byte_valid = !abort && state_q == ST_CHECK && frame_ok;
   assign byte_error = !abort && state_q == ST_CHECK && !frame_ok;
   assign start_error = start_err;
   assign fall = fall_q;
   assign busy = state_q != ST_IDLE;
endmodule

// File: rtl/ps2_mouse_decoder.sv
// ps2_mouse_decoder: assembles PS/2 mouse packets into clamped cursor position and buttons
module ps2_mouse_decoder
   import ps2_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic        lmb,
   output logic        mmb,
   output logic        rmb,
   output logic [15:0] mouse_x,
   output logic [15:0] mouse_y,
   output logic        packet_valid,
   output logic        frame_error
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic signed [17:0] X_MAX = 18'(SCREEN_W - 1);
   localparam logic signed [17:0] Y_MAX = 18'(SCREEN_H - 1);
   logic [7:0] byte_data;
   logic byte_valid, byte_error, start_error, fall, busy, active, timeout;
   logic [1:0] idx_q, idx_d;
   pkt_hdr_t hdr_q, hdr_d;
   logic [7:0] dx_q, dx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic lmb_q, lmb_d, mmb_q, mmb_d, rmb_q, rmb_d, pv_q, pv_d, fe_q, fe_d;
   logic [15:0] x_q, x_d, y_q, y_d, x_clamp, y_clamp;
   logic signed [17:0] dx, dy, nx, ny;
   ps2_rx_frame u_rx (
      .clk(clk),
      .reset(reset),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .abort(timeout),
      .byte_data(byte_data),
      .byte_valid(byte_valid),
      .byte_error(byte_error),
      .start_error(start_error),
      .fall(fall),
      .busy(busy)
   );
   // Deltas are formed from the stored header/dx and the live dy byte, so the update lands with byte 2.
   always_comb begin
      active = busy || idx_q != PKT_B0;
      timeout = active && tmo_q == TW'(TIMEOUT);
      tmo_d = (fall || !active || timeout) ? '0 : tmo_q + TW'(1);
      dx = hdr_q.x_ovf ? '0 : {{10{hdr_q.x_sign}}, dx_q};
      dy = hdr_q.y_ovf ? '0 : {{10{hdr_q.y_sign}}, byte_data};
      nx = $signed({2'b00, x_q}) + dx;
      ny = $signed({2'b00, y_q}) - dy;
      x_clamp = nx < 0 ? '0 : nx > X_MAX ? X_MAX[15:0] : nx[15:0];
      y_clamp = ny < 0 ? '0 : ny > Y_MAX ? Y_MAX[15:0] : ny[15:0];
      idx_d = idx_q;
      hdr_d = hdr_q;
      dx_d = dx_q;
      lmb_d = lmb_q;
      mmb_d = mmb_q;
      rmb_d = rmb_q;
      x_d = x_q;
      y_d = y_q;
      pv_d = 1'b0;
      fe_d = 1'b0;
      if (timeout) begin
         idx_d = PKT_B0;
         fe_d = 1'b1;
      end else if (byte_error) begin
         idx_d = PKT_B0;
         fe_d = 1'b1;
      end else if (start_error)
         fe_d = 1'b1;
      else if (byte_valid)
         unique case (idx_q)
            PKT_B0: begin
               fe_d = !byte_data[B0_SYNC];
               idx_d = byte_data[B0_SYNC] ? PKT_B1 : PKT_B0;
               hdr_d = byte_data[B0_SYNC] ? hdr_of(byte_data) : hdr_q;
            end
            PKT_B1: begin
               dx_d = byte_data;
               idx_d = PKT_B2;
            end
            default: begin
               idx_d = PKT_B0;
               pv_d = 1'b1;
               lmb_d = hdr_q.l;
               mmb_d = hdr_q.m;
               rmb_d = hdr_q.r;
               x_d = x_clamp;
               y_d = y_clamp;
            end
         endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         idx_q <= PKT_B0;
         hdr_q <= '0;
         dx_q <= '0;
         tmo_q <= '0;
         lmb_q <= 1'b0;
         mmb_q <= 1'b0;
         rmb_q <= 1'b0;
         x_q <= 16'(SCREEN_W / 2);
         y_q <= 16'(SCREEN_H / 2);
         pv_q <= 1'b0;
         fe_q <= 1'b0;
      end else begin
         idx_q <= idx_d;
         hdr_q <= hdr_d;
         dx_q <= dx_d;
         tmo_q <= tmo_d;
         lmb_q <= lmb_d;
         mmb_q <= mmb_d;
         rmb_q <= rmb_d;
         x_q <= x_d;
         y_q <= y_d;
         pv_q <= pv_d;
         fe_q <= fe_d;
      end
   assign lmb = lmb_q;
   assign mmb = mmb_q;
   assign rmb = rmb_q;
   assign mouse_x = x_q;
   assign mouse_y = y_q;
   assign packet_valid = pv_q;
   assign frame_error = fe_q;
endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// tb_ps2_mouse_decoder: directed packet vectors plus hand-written error, timeout and reset sequences
module tb_ps2_mouse_decoder;
   localparam int TMO = 2000;
   logic clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic lmb, mmb, rmb, packet_valid, frame_error;
   logic [15:0] mouse_x, mouse_y;
   ps2_mouse_decoder #(.SCREEN_W(640), .SCREEN_H(480), .TIMEOUT(TMO)) dut (
      .clk(clk),
      .reset(reset),
      .ps2_clk(ps2_clk),
      .ps2_data(ps2_data),
      .lmb(lmb),
      .mmb(mmb),
      .rmb(rmb),
      .mouse_x(mouse_x),
      .mouse_y(mouse_y),
      .packet_valid(packet_valid),
      .frame_error(frame_error)
   );
   always #5 clk = ~clk;
   int pv_cnt = 0, fe_cnt = 0, clash_cnt = 0;
   logic pv_prev = 1'b0, fe_prev = 1'b0;
   always @(negedge clk) begin
      if (packet_valid) pv_cnt++;
      if (frame_error) fe_cnt++;
      if ((packet_valid && frame_error) || (packet_valid && pv_prev) || (frame_error && fe_prev)) clash_cnt++;
      pv_prev = packet_valid;
      fe_prev = frame_error;
   end
   int n_vec = 0, n_err = 0;
   int pv0, fe0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
   endtask
   task automatic send_bit(input logic b);
      ps2_data = b;
      tick(4);
      ps2_clk = 1'b0;
      tick(8);
      ps2_clk = 1'b1;
      tick(4);
   endtask
   task automatic send_byte(input logic [7:0] b, input logic bad);
      logic [10:0] f;
      f = {1'b1, ~^b ^ bad, b, 1'b0};
      for (int i = 0; i < 11; i++) send_bit(f[i]);
      ps2_data = 1'b1;
      tick(10);
   endtask
   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      send_byte(b0, 1'b0);
      send_byte(b1, 1'b0);
      send_byte(b2, 1'b0);
   endtask
   task automatic mark();
      pv0 = pv_cnt;
      fe0 = fe_cnt;
   endtask
   task automatic check_out(input string name, input logic l, input logic m, input logic r,
                            input int x, input int y, input int dpv, input int dfe);
      @(negedge clk);
      chk({name, " lmb"}, 32'(lmb), 32'(l));
      chk({name, " mmb"}, 32'(mmb), 32'(m));
      chk({name, " rmb"}, 32'(rmb), 32'(r));
      chk({name, " x"}, 32'(mouse_x), x);
      chk({name, " y"}, 32'(mouse_y), y);
      chk({name, " pv pulses"}, pv_cnt - pv0, dpv);
      chk({name, " fe pulses"}, fe_cnt - fe0, dfe);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(2);
   endtask
   typedef struct {
      logic rst;
      logic [7:0] b0, b1, b2;
      logic l, m, r;
      int x, y;
   } vec_t;
   vec_t tv[$];
   initial begin
      tv.push_back('{1'b0, 8'h09, 8'h05, 8'h03, 1'b1, 1'b0, 1'b0, 325, 237});
      tv.push_back('{1'b1, 8'h38, 8'hF6, 8'hFE, 1'b0, 1'b0, 1'b0, 310, 242});
      tv.push_back('{1'b0, 8'h18, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 182, 242});
      tv.push_back('{1'b0, 8'h18, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 54, 242});
      tv.push_back('{1'b0, 8'h18, 8'hCF, 8'h00, 1'b0, 1'b0, 1'b0, 5, 242});
      tv.push_back('{1'b0, 8'h18, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 0, 242});
      tv.push_back('{1'b0, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 127, 242});
      tv.push_back('{1'b0, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 254, 242});
      tv.push_back('{1'b0, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 381, 242});
      tv.push_back('{1'b0, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 508, 242});
      tv.push_back('{1'b0, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 635, 242});
      tv.push_back('{1'b0, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 639, 242});
      tv.push_back('{1'b0, 8'h08, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 639, 242});
      tv.push_back('{1'b0, 8'h48, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 639, 226});
      tv.push_back('{1'b0, 8'h08, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 639, 99});
      tv.push_back('{1'b0, 8'h08, 8'h00, 8'h7F, 1'b0, 1'b0, 1'b0, 639, 0});
      tv.push_back('{1'b0, 8'h28, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 639, 128});
      tv.push_back('{1'b0, 8'h28, 8'h00, 8'h81, 1'b0, 1'b0, 1'b0, 639, 255});
      tv.push_back('{1'b0, 8'h28, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 639, 383});
      tv.push_back('{1'b0, 8'h28, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 639, 479});
      tv.push_back('{1'b0, 8'h0C, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 639, 479});
      tv.push_back('{1'b0, 8'h98, 8'hFF, 8'h50, 1'b0, 1'b0, 1'b0, 638, 479});
      tv.push_back('{1'b0, 8'h0F, 8'h01, 8'hFF, 1'b1, 1'b1, 1'b1, 639, 224});
      tick(3);
      mark();
      check_out("reset", 1'b0, 1'b0, 1'b0, 320, 240, 0, 0);
      chk("reset pv level", 32'(packet_valid), 0);
      chk("reset fe level", 32'(frame_error), 0);
      reset = 1'b0;
      tick(2);
      foreach (tv[i]) begin
         if (tv[i].rst) begin
            do_reset();
            mark();
            check_out($sformatf("vec%0d reset", i), 1'b0, 1'b0, 1'b0, 320, 240, 0, 0);
         end
         mark();
         send_pkt(tv[i].b0, tv[i].b1, tv[i].b2);
         check_out($sformatf("vec%0d", i), tv[i].l, tv[i].m, tv[i].r, tv[i].x, tv[i].y, 1, 0);
      end
      do_reset();
      mark();
      send_byte(8'h09, 1'b0);
      send_byte(8'h05, 1'b1);
      check_out("parity err", 1'b0, 1'b0, 1'b0, 320, 240, 0, 1);
      mark();
      send_pkt(8'h0A, 8'h01, 8'h00);
      check_out("after parity", 1'b0, 1'b0, 1'b1, 321, 240, 1, 0);
      mark();
      send_byte(8'h00, 1'b0);
      check_out("resync byte", 1'b0, 1'b0, 1'b1, 321, 240, 0, 1);
      mark();
      send_pkt(8'h09, 8'h02, 8'h00);
      check_out("after resync", 1'b1, 1'b0, 1'b0, 323, 240, 1, 0);
      mark();
      send_bit(1'b1);
      tick(10);
      check_out("start bit err", 1'b1, 1'b0, 1'b0, 323, 240, 0, 1);
      mark();
      for (int i = 0; i < 5; i++) send_bit(1'b0);
      ps2_data = 1'b1;
      tick(TMO + 100);
      check_out("bit timeout", 1'b1, 1'b0, 1'b0, 323, 240, 0, 1);
      mark();
      send_pkt(8'h08, 8'h05, 8'h00);
      check_out("after bit timeout", 1'b0, 1'b0, 1'b0, 328, 240, 1, 0);
      mark();
      send_byte(8'h0A, 1'b0);
      tick(TMO + 100);
      check_out("byte timeout", 1'b0, 1'b0, 1'b0, 328, 240, 0, 1);
      mark();
      send_pkt(8'h09, 8'h05, 8'h01);
      check_out("after byte timeout", 1'b1, 1'b0, 1'b0, 333, 239, 1, 0);
      mark();
      send_byte(8'h0A, 1'b0);
      send_byte(8'h10, 1'b0);
      reset = 1'b1;
      #1;
      chk("mid reset x", 32'(mouse_x), 320);
      chk("mid reset y", 32'(mouse_y), 240);
      chk("mid reset lmb", 32'(lmb), 0);
      tick(3);
      reset = 1'b0;
      tick(2);
      check_out("mid reset quiet", 1'b0, 1'b0, 1'b0, 320, 240, 0, 0);
      mark();
      send_pkt(8'h0A, 8'h01, 8'h00);
      check_out("after mid reset", 1'b0, 1'b0, 1'b1, 321, 240, 1, 0);
      chk("pulse overlap or width", clash_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
